butterfly_arbiter: RTL
======================

// Module: butterfly_arbiter
// PURPOSE
// - Shares one ButterflyVRTL instance among NREQ requesters (FFT stage lanes) using round-robin arbitration.
// - Exactly one transaction is in flight at a time. The arbiter latches the winner's operands,
//   sequences the butterfly handshakes, captures c/d and returns them to the winner.
// - Sits between FFT stage controllers and the butterfly; the butterfly and arbiter share clk/reset.
// PARAMETERS
// - n     32  operand/result word width (fixed point)
// - d     16  fractional bits; passed through only, no arithmetic here
// - NREQ   4  number of requesters, 2..16; IDW = $clog2(NREQ)
// PORTS
// - clk          in   1        clock, rising edge
// - reset        in   1        asynchronous, active-low reset
// - req_recv_val in   NREQ     per-requester operand valid
// - req_recv_rdy out  NREQ     per-requester operand accept (one-hot or zero)
// - req_ar..req_wc in NREQ*n   six packed operand buses; requester i uses slice [i*n +: n]
// - req_send_val out  NREQ     per-requester result valid (one-hot or zero)
// - req_send_rdy in   NREQ     per-requester result accept
// - rsp_cr,rsp_cc,rsp_dr,rsp_dc out n  shared result bus, qualified by req_send_val
// - bf_recv_val  out  1        to butterfly recv_val
// - bf_recv_rdy  in   1        from butterfly recv_rdy
// - bf_ar..bf_wc out  n        six operand buses to butterfly, registered
// - bf_send_val  in   1        from butterfly send_val
// - bf_send_rdy  out  1        to butterfly send_rdy
// - bf_cr..bf_dc in   n        four result buses from butterfly
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE; ptr=0; all outputs 0, including every operand/result register.
// - Reset mid-transaction aborts it with no response; the butterfly is reset by the same signal.
// - FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE
//   - winner = first i with req_recv_val[i], scanning from ptr upward, mod NREQ.
//   - req_recv_rdy[winner]=1, combinational from req_recv_val; all other rdy bits are 0.
//   - If any req_recv_val is high: latch the winner's six operands into bf_* registers, latch
//     gnt=winner, go to ISSUE. Otherwise stay in IDLE.
// - ISSUE
//   - bf_recv_val=1.
//   - On bf_recv_val & bf_recv_rdy, go to WAIT. Hold while bf_recv_rdy=0.
// - WAIT
//   - Entered the cycle after the issue handshake, so a stale bf_send_val from the prior op has
//     already been cleared by the butterfly.
//   - On bf_send_val=1: capture bf_cr..bf_dc into rsp_*, assert bf_send_rdy for exactly that cycle,
//     go to RESP.
// - RESP
//   - req_send_val[gnt]=1 and rsp_* held stable.
//   - On req_send_rdy[gnt]: ptr <= (gnt+1) mod NREQ, go to IDLE.
// - Every other output bit is 0 outside the states named above.
// - Fairness: a requester holding val waits at most NREQ-1 transactions.
// - A requester may drop val before it is granted (no penalty). It must not drop val while rdy is high.
// - Requesters are blocked in RESP. The next grant happens only after the response is taken
//   (no overlap).
// - Minimum latency: req handshake cycle T -> bf_recv_val at T+1 -> (butterfly latency L) ->
//   req_send_val at T+1+1+L+1.
// - With mult=0 the butterfly result follows the issue handshake by 2 cycles:
//   req_send_val at T+4 when all rdys are high.
// - Simultaneous events:
//   - req_send_rdy and a new req_recv_val in the same RESP cycle: the new request is not accepted
//     until the following IDLE cycle.
//   - All NREQ requests valid: granted in order ptr, ptr+1, ...
// - No arithmetic in this block. Data is passed bit-exact, n bits, no truncation.
// CONFIGURATION
// - BUTTERFLY_ARB_PERF_EN defined:
//   - Adds outputs perf_ops (32b) and perf_busy (32b), both 0 on reset.
//   - perf_ops increments on each RESP completion.
//   - perf_busy increments every cycle state!=IDLE.
//   - Both saturate at 32'hFFFF_FFFF.
// - BUTTERFLY_ARB_PERF_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// - Reset mid-WAIT (assert reset 3 cycles after issue) -> all outputs 0 immediately;
//   after release, ptr=0 and the next request from req 2 is granted normally.
// - Single request, req1 ar=0x0001_0000 (1.0), br=0x0002_0000, wr=0x0001_0000, imag=0,
//   mult=0 butterfly -> req_send_val[1] only; rsp_cr=0x0003_0000, rsp_dr=0xFFFF_0000.
// - All four requesters valid continuously, tags in operand ar -> grant order 0,1,2,3,0,
//   responses return to the matching requester with the matching data.
// - req_send_rdy[g] held low 10 cycles -> rsp_* and req_send_val stable;
//   bf_recv_val stays 0; no new grant.
// - bf_recv_rdy held low 5 cycles in ISSUE -> bf_recv_val and bf_ar..bf_wc stable; one handshake only.
// - PERF_EN build: 3 back-to-back ops -> perf_ops=3; perf_busy equals the cycles counted by the bench.

Source files
------------

// File: rtl/butterfly_arbiter.sv
// ---------------------------------------------------------------------------
// butterfly_arbiter
//
// Shares a single butterfly unit among NREQ requesters (FFT stage lanes)
// with round-robin arbitration. Only one transaction is in flight at a time:
// the winner's six operands are latched toward the butterfly, the butterfly
// handshakes are sequenced, the four results are captured and then returned
// to the winner on the shared response bus.
//
// Parameters
//   n     operand/result word width (fixed point)
//   d     fractional bits; carried for configuration only, no arithmetic here
//   NREQ  number of requesters, 2..16
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   req_recv_val / req_recv_rdy   per-requester operand handshake (rdy one-hot)
//   req_ar..req_wc                packed operands, requester i at [i*n +: n]
//   req_send_val / req_send_rdy   per-requester result handshake (val one-hot)
//   rsp_cr, rsp_cc, rsp_dr, rsp_dc shared result bus, qualified by req_send_val
//   bf_recv_val / bf_recv_rdy     operand handshake toward the butterfly
//   bf_ar..bf_wc                  registered operands toward the butterfly
//   bf_send_val / bf_send_rdy     result handshake from the butterfly
//   bf_cr..bf_dc                  results from the butterfly
//
// Optional feature (macro BUTTERFLY_ARB_PERF_EN)
//   perf_ops   completed transactions, saturating at 32'hFFFF_FFFF
//   perf_busy  cycles spent outside IDLE, saturating at 32'hFFFF_FFFF
// ---------------------------------------------------------------------------
module butterfly_arbiter #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [NREQ-1:0]   req_recv_val,
    output logic [NREQ-1:0]   req_recv_rdy,
    input  logic [NREQ*n-1:0] req_ar,
    input  logic [NREQ*n-1:0] req_ac,
    input  logic [NREQ*n-1:0] req_br,
    input  logic [NREQ*n-1:0] req_bc,
    input  logic [NREQ*n-1:0] req_wr,
    input  logic [NREQ*n-1:0] req_wc,

    output logic [NREQ-1:0]   req_send_val,
    input  logic [NREQ-1:0]   req_send_rdy,
    output logic [n-1:0]      rsp_cr,
    output logic [n-1:0]      rsp_cc,
    output logic [n-1:0]      rsp_dr,
    output logic [n-1:0]      rsp_dc,

    output logic              bf_recv_val,
    input  logic              bf_recv_rdy,
    output logic [n-1:0]      bf_ar,
    output logic [n-1:0]      bf_ac,
    output logic [n-1:0]      bf_br,
    output logic [n-1:0]      bf_bc,
    output logic [n-1:0]      bf_wr,
    output logic [n-1:0]      bf_wc,

    input  logic              bf_send_val,
    output logic              bf_send_rdy,
    input  logic [n-1:0]      bf_cr,
    input  logic [n-1:0]      bf_cc,
    input  logic [n-1:0]      bf_dr,
    input  logic [n-1:0]      bf_dc
`ifdef BUTTERFLY_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy
`endif
);

    localparam int IDW = $clog2(NREQ);

    // Catch unusable configurations at elaboration rather than in silicon.
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("butterfly_arbiter: NREQ must be in 2..16");
    end
    if (d < 0 || d >= n) begin : g_bad_frac
        $error("butterfly_arbiter: d must be in 0..n-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt;
    logic [IDW-1:0]  winner;
    logic            any_req;
    logic            resp_done;

    // Requester index k positions after base, wrapping at NREQ (which need
    // not be a power of two, so a plain IDW-bit add would not wrap right).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                                input int             k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
        if (int'(g) == NREQ - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    // Round-robin pick: walk downward so the candidate closest to ptr is
    // the last one written and therefore wins.
    always_comb begin
        any_req = |req_recv_val;
        winner  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_recv_val[rr_index(ptr, k)]) begin
                winner = rr_index(ptr, k);
            end
        end
    end

    // Accept is combinational so a requester is taken in the same IDLE cycle
    // it presents val; gated by reset so every output reads 0 during reset.
    always_comb begin
        req_recv_rdy = '0;
        if (reset && state == S_IDLE && any_req) begin
            req_recv_rdy[winner] = 1'b1;
        end
    end

    always_comb begin
        req_send_val = '0;
        if (state == S_RESP) begin
            req_send_val[gnt] = 1'b1;
        end
    end

    assign bf_recv_val = (state == S_ISSUE);
    // Only acknowledge the butterfly in the cycle its result is captured.
    assign bf_send_rdy = (state == S_WAIT) && bf_send_val;
    assign resp_done   = (state == S_RESP) && req_send_rdy[gnt];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            gnt    <= '0;
            bf_ar  <= '0;
            bf_ac  <= '0;
            bf_br  <= '0;
            bf_bc  <= '0;
            bf_wr  <= '0;
            bf_wc  <= '0;
            rsp_cr <= '0;
            rsp_cc <= '0;
            rsp_dr <= '0;
            rsp_dc <= '0;
        end else begin
            case (state)
                // ---- grant: latch winner operands toward the butterfly ----
                S_IDLE: begin
                    if (any_req) begin
                        bf_ar <= req_ar[int'(winner)*n +: n];
                        bf_ac <= req_ac[int'(winner)*n +: n];
                        bf_br <= req_br[int'(winner)*n +: n];
                        bf_bc <= req_bc[int'(winner)*n +: n];
                        bf_wr <= req_wr[int'(winner)*n +: n];
                        bf_wc <= req_wc[int'(winner)*n +: n];
                        gnt   <= winner;
                        state <= S_ISSUE;
                    end
                end
                // ---- issue: hold operands until the butterfly accepts ----
                S_ISSUE: begin
                    if (bf_recv_rdy) begin
                        state <= S_WAIT;
                    end
                end
                // ---- wait: capture the butterfly result ----
                S_WAIT: begin
                    if (bf_send_val) begin
                        rsp_cr <= bf_cr;
                        rsp_cc <= bf_cc;
                        rsp_dr <= bf_dr;
                        rsp_dc <= bf_dc;
                        state  <= S_RESP;
                    end
                end
                // ---- respond: hold result until the winner takes it ----
                S_RESP: begin
                    if (req_send_rdy[gnt]) begin
                        ptr   <= next_ptr(gnt);
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BUTTERFLY_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (resp_done) begin
                perf_ops <= sat_inc(perf_ops);
            end
            if (state != S_IDLE) begin
                perf_busy <= sat_inc(perf_busy);
            end
        end
    end
`endif

endmodule
